// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: quadrant tags from the input pre-rotation stage
// and the default data/tag widths used by the rotator and its neighbours.
package cordic_pkg;

  // Quadrant codes produced by the input pre-rotation stage
  localparam int QUAD_1 = 1;
  localparam int QUAD_2 = 2;
  localparam int QUAD_3 = 3;
  localparam int QUAD_4 = 4;

  // Default widths shared across the CORDIC sine/cosine path
  localparam int CORDIC_WIDTH = 20;
  localparam int CORDIC_QW    = 3;

endpackage

// File: rtl/cordic_quad_fold.sv
// Combinational quadrant fold-back for raw CORDIC (x, y) results.
// Optional macro OUTMAP_SAT_EN: negating the most negative value clamps to
// the most positive value and raises sat; otherwise negation wraps and sat=0.
module cordic_quad_fold
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int QW    = CORDIC_QW
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic        [QW-1:0]    quad,
  output logic signed [WIDTH-1:0] fx,
  output logic signed [WIDTH-1:0] fy,
  output logic                    sat
);

  logic signed [WIDTH-1:0] neg_x;
  logic signed [WIDTH-1:0] neg_y;
  logic                    sat_x;
  logic                    sat_y;

`ifdef OUTMAP_SAT_EN
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  // Saturating negation: only the most negative value cannot be negated
  always_comb begin
    sat_x = (x == MIN_VAL);
    sat_y = (y == MIN_VAL);
    neg_x = sat_x ? MAX_VAL : -x;
    neg_y = sat_y ? MAX_VAL : -y;
  end
`else
  // Plain two's complement negation; the most negative value wraps onto itself
  always_comb begin
    sat_x = 1'b0;
    sat_y = 1'b0;
    neg_x = -x;
    neg_y = -y;
  end
`endif

  // Quadrant fold-back: Q2 rotates by +90 degrees, Q3 by 180, others pass through
  always_comb begin
    fx  = x;
    fy  = y;
    sat = 1'b0;
    if (quad == QW'(QUAD_2)) begin
      fx  = neg_y;
      fy  = x;
      sat = sat_y;
    end else if (quad == QW'(QUAD_3)) begin
      fx  = neg_x;
      fy  = neg_y;
      sat = sat_x | sat_y;
    end else if ((quad == QW'(QUAD_1)) || (quad == QW'(QUAD_4))) begin
      fx  = x;
      fy  = y;
    end
  end

endmodule

// File: rtl/cordic_quadrant_map_pipe.sv
// Quadrant-correction stage with a 2-entry output FIFO and valid/ready
// handshakes on both sides. in_ready depends only on registered state and rst.
// Optional macro OUTMAP_SAT_EN: stores a per-sample saturation flag (out_sat).
module cordic_quadrant_map_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH = CORDIC_WIDTH,
  parameter int QW    = CORDIC_QW,
  parameter int TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic        [QW-1:0]    in_quad,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic        [TAG_W-1:0] out_tag,
  output logic                    out_sat
);

`ifdef OUTMAP_SAT_EN
  localparam int DW = 2*WIDTH + TAG_W + 1;
`else
  localparam int DW = 2*WIDTH + TAG_W;
`endif

  logic signed [WIDTH-1:0] map_x;
  logic signed [WIDTH-1:0] map_y;
  logic                    map_sat;
  logic [DW-1:0]           new_entry;
  logic [DW-1:0]           r0;
  logic [DW-1:0]           r1;
  logic [1:0]              count;
  logic                    push;
  logic                    pop;

  cordic_quad_fold #(
    .WIDTH (WIDTH),
    .QW    (QW)
  ) u_fold (
    .x    (in_x),
    .y    (in_y),
    .quad (in_quad),
    .fx   (map_x),
    .fy   (map_y),
    .sat  (map_sat)
  );

`ifdef OUTMAP_SAT_EN
  assign new_entry = {map_sat, map_x, map_y, in_tag};
  assign out_sat   = r0[DW-1];
`else
  assign new_entry = {map_x, map_y, in_tag};
  assign out_sat   = map_sat;
`endif

  assign in_ready  = (count != 2'd2) & ~rst;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_tag   = r0[TAG_W-1:0];
  assign out_y     = r0[TAG_W +: WIDTH];
  assign out_x     = r0[TAG_W+WIDTH +: WIDTH];

  // Two-entry FIFO: r0 is always the head presented on the output
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      r0    <= '0;
      r1    <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) r0 <= new_entry;
          else               r1 <= new_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          r0    <= r1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            r0 <= new_entry;
          end else begin
            r0 <= r1;
            r1 <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_quadrant_map_pipe.sv
// Scoreboard bench for cordic_quadrant_map_pipe. The driver pushes expected
// results from an arithmetic reference model on every accepted input; the
// monitor compares the head of the queue whenever the DUT shows out_valid.
// Honours OUTMAP_SAT_EN when deciding the expected overflow behaviour.
module tb_cordic_quadrant_map_pipe;

  localparam int W  = 20;
  localparam int QW = 3;
  localparam int TW = 8;
  localparam longint MAX_V = (longint'(1) << (W-1)) - 1;
  localparam int MIN_I = -(1 << (W-1));

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic [TW-1:0]       tag;
    logic                sat;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_y;
  logic [QW-1:0]       in_quad;
  logic [TW-1:0]       in_tag;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_x;
  logic signed [W-1:0] out_y;
  logic [TW-1:0]       out_tag;
  logic                out_sat;

  exp_t sb[$];
  int   checks;
  int   errors;
  bit   prev_rst;

  cordic_quadrant_map_pipe #(
    .WIDTH (W),
    .QW    (QW),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_quad   (in_quad),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bring an out-of-range negation result back into the signed range
  function automatic longint fold_val(input longint v, output bit s);
    s = 1'b0;
    if (v > MAX_V) begin
`ifdef OUTMAP_SAT_EN
      s = 1'b1;
      return MAX_V;
`else
      return v - (longint'(1) << W);
`endif
    end
    return v;
  endfunction

  // Reference model: rotate by the quadrant using plain integer arithmetic
  function automatic exp_t ref_model(input int x, input int y, input int quad, input int tag);
    exp_t   e;
    longint rx;
    longint ry;
    bit     sx;
    bit     sy;
    case (quad)
      2:       begin rx = -longint'(y); ry = longint'(x);  end
      3:       begin rx = -longint'(x); ry = -longint'(y); end
      default: begin rx = longint'(x);  ry = longint'(y);  end
    endcase
    e.x   = W'(fold_val(rx, sx));
    e.y   = W'(fold_val(ry, sy));
    e.tag = TW'(tag);
    e.sat = sx | sy;
    return e;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; records the expected result if the input transfers
  task automatic applyStimulus(input bit r, input bit v, input int x, input int y,
                               input int quad, input int tag, input bit ordy,
                               output bit acc);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_x      = W'(x);
    in_y      = W'(y);
    in_quad   = QW'(quad);
    in_tag    = TW'(tag);
    out_ready = ordy;
    #3;
    acc = in_valid && in_ready;
    if (acc) sb.push_back(ref_model(x, y, quad, tag));
  endtask

  function automatic int rand_data();
    logic signed [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 7) == 0) v = W'(MIN_I);
    return int'(v);
  endfunction

  // Monitor: checks handshake state and head data against the scoreboard
  initial begin
    exp_t e;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      checkOutput("in_ready", longint'(in_ready), longint'(!rst && sb.size() < 2));
      checkOutput("out_valid", longint'(out_valid), longint'(sb.size() != 0));
      if (prev_rst) begin
        checkOutput("rst_out_x", longint'(out_x), 0);
        checkOutput("rst_out_y", longint'(out_y), 0);
        checkOutput("rst_out_tag", longint'(out_tag), 0);
        checkOutput("rst_out_sat", longint'(out_sat), 0);
      end
      if (out_valid && sb.size() != 0) begin
        e = sb[0];
        checkOutput("out_x", longint'(out_x), longint'(e.x));
        checkOutput("out_y", longint'(out_y), longint'(e.y));
        checkOutput("out_tag", longint'(out_tag), longint'(e.tag));
        checkOutput("out_sat", longint'(out_sat), longint'(e.sat));
        if (out_ready) void'(sb.pop_front());
      end
      prev_rst = rst;
      #3;
      if (rst) sb.delete();
    end
  end

  // Stimulus sequence
  initial begin
    bit acc;
    int tag;
    int stalls;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_quad   = '0;
    in_tag    = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, acc);
    applyStimulus(1, 1, 77, 88, 2, 99, 1, acc);

    $display("[TB] directed quadrant cases");
    applyStimulus(0, 1, 1000, 200, 2, 1, 1, acc);
    applyStimulus(0, 1, 1000, 200, 3, 2, 1, acc);
    applyStimulus(0, 1, 1000, 200, 1, 3, 1, acc);
    applyStimulus(0, 1, 1000, 200, 4, 4, 1, acc);
    applyStimulus(0, 1, 1000, 200, 7, 5, 1, acc);
    applyStimulus(0, 1, 1000, 200, 0, 6, 1, acc);
    applyStimulus(0, 1, MIN_I, 5, 3, 7, 1, acc);
    applyStimulus(0, 1, 123, MIN_I, 2, 8, 1, acc);
    applyStimulus(0, 0, 555, 666, 3, 9, 1, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    $display("[TB] back-pressure stream");
    tag    = 0;
    stalls = 0;
    for (int c = 0; c < 60 && tag < 10; c++) begin
      applyStimulus(0, 1, 1000 + tag, -3 * tag, (tag % 4) + 1, tag, !(c >= 3 && c <= 6), acc);
      if (acc) tag++;
      else stalls++;
    end
    checkOutput("bp_sent", tag, 10);
    checkOutput("bp_stalls", stalls, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    $display("[TB] full-rate random stream");
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, rand_data(), rand_data(), int'($urandom_range(0, 7)), i, 1, acc);
      if (!acc) stalls++;
    end
    checkOutput("full_rate_stalls", stalls, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1, 11, 22, 2, 200, 0, acc);
    applyStimulus(0, 1, 33, 44, 3, 201, 0, acc);
    applyStimulus(1, 1, 55, 66, 1, 202, 0, acc);
    checkOutput("rst_accept", longint'(acc), 0);
    applyStimulus(0, 1, 300, -400, 2, 203, 1, acc);
    checkOutput("post_rst_accept", longint'(acc), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);

    $display("[TB] random handshake soak");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), rand_data(), rand_data(),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), acc);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
    checkOutput("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_quadrant_map_pipe.md
# cordic_quadrant_map_pipe

Pipelined, parametrised quadrant-correction stage for the CORDIC sine/cosine path. Takes raw (x, y) CORDIC rotator results plus the quadrant tag produced by input pre-rotation. Applies the quadrant fold-back and returns the corrected cos/sin pair through a valid/ready handshake with a 2-entry output buffer. Sits between the CORDIC iteration pipeline and the DAC/sample sink, and can absorb sink back-pressure without dropping samples.

## Interface
- WIDTH, 20, signed data width of x/y in and out
- QW, 3, quadrant tag width
- TAG_W, 8, user sidecar (sample index/channel) carried alongside data
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_x  in  WIDTH  signed CORDIC x (cos, unmapped)
- in_y  in  WIDTH  signed CORDIC y (sin, unmapped)
- in_quad  in  QW  quadrant code: 1..4 = Q1..Q4; any other value = pass-through
- in_tag  in  TAG_W  sidecar, passed unchanged
- out_valid  out  1  output sample valid
- out_ready  in  1  sink accepts output
- out_x  out  WIDTH  corrected cos
- out_y  out  WIDTH  corrected sin
- out_tag  out  TAG_W  sidecar of the output sample
- out_sat  out  1  output sample had a negation clamped; 0 when OUTMAP_SAT_EN is undefined

## Operation
- Mapping, computed combinationally on the input side:
  - Q2: x' = -y, y' = x
  - Q3: x' = -x, y' = -y
  - Q1, Q4, invalid codes: x' = x, y' = y
- Negation is full-width two's complement. -(−2^(WIDTH−1)) is the only overflow case (see Configuration).
- Mapped sample plus tag is written into a 2-entry FIFO: storage regs r0 (head) and r1, and a count of 0..2.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- in_ready = (count < 2) & !rst. It depends only on registered state; there is no combinational path from out_ready.
- out_valid = (count != 0). out_x/out_y/out_tag/out_sat always show the head entry.
- Simultaneous input and output transfer at count=1: the head is replaced by the new sample and count stays 1.
- Simultaneous transfers at count=2: r1 moves to head, the new sample goes to r1, and count stays 2. This cannot happen, because in_ready=0 when count=2.
- Output data is held stable while out_valid & !out_ready.
- Input values while in_valid=0 are ignored.
- Order is strictly FIFO. No sample is dropped or duplicated.

## Timing
- Latency is 1 cycle: a sample accepted at edge N is on out_* with out_valid=1 in the cycle after edge N.
- Throughput is 1 sample/cycle while out_ready=1.
- After out_ready falls, one further input is accepted, then in_ready=0 until an output transfer occurs.
- Reset, when rst is high at an edge:
  - count=0, out_valid=0, out_x=0, out_y=0, out_tag=0, out_sat=0.
  - in_ready=0 during the reset cycle(s) and 1 in the first cycle after rst falls.
- Reset mid-operation discards all buffered samples. An in_valid coincident with rst is not accepted.

## Configuration
- OUTMAP_SAT_EN defined:
  - Negating −2^(WIDTH−1) yields 2^(WIDTH−1)−1.
  - out_sat=1 for that sample (per sample, stored in the FIFO).
- OUTMAP_SAT_EN undefined:
  - The negation wraps, so −2^(WIDTH−1) stays −2^(WIDTH−1).
  - out_sat is tied to 0 and its storage is removed.

## Structure
- Shared package cordic_pkg holds:
  - Quadrant localparams QUAD_1=1, QUAD_2=2, QUAD_3=3, QUAD_4=4.
  - The default WIDTH/QW constants shared with the rotator and the input pre-rotation stage.
- Sub-module cordic_quad_fold is the natural split. It is combinational: mapping plus saturating negate, parametrised by WIDTH, and outputs x', y', sat.
- The top level holds the 2-entry FIFO and the handshake.

## Test plan
- WIDTH=20, out_ready=1:
  - in (x=1000, y=200, quad=2) -> next cycle out (x=−200, y=1000), out_sat=0.
  - quad=3, (1000, 200) -> (−1000, −200).
  - quad=1, quad=4 and quad=7 with (1000, 200) -> (1000, 200).
- quad=3, x=−524288, y=5:
  - With OUTMAP_SAT_EN -> out_x=524287, out_y=−5, out_sat=1.
  - Without OUTMAP_SAT_EN -> out_x=−524288, out_sat=0.
- Back-pressure:
  - Stream tags 0..9 with out_ready low for cycles 3–6 -> in_ready drops after two buffered samples.
  - Outputs read back tags 0..9 in order, none lost or repeated, data stable while stalled.
- Full-rate streaming, 100 random samples, out_ready=1 -> one output per cycle; each result matches the reference model exactly, with a 1-cycle lag.
- Reset mid-stream:
  - Assert rst for 1 cycle with count=2 -> out_valid=0, all outputs 0, in_ready=0 during rst.
  - in_ready=1 the cycle after rst falls, and the first post-reset sample emerges with latency 1.
- Random in_valid/out_ready (50% each) for 10k cycles -> scoreboard matches, and in_ready never depends combinationally on out_ready.
